// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory with a combinational read and a synchronous write.
// Define LSU_ERR_EN to enable alignment and funct3 checking; otherwise bad requests are normalised and executed.
module dmem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_e              state_q, state_d;
    logic                store_q, store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_err;
    logic [2:0]          req_f3;
    logic [ADDR_W-1:0]   req_addr;
    logic [ADDR_W-1:0]   word_addr;

    // funct3[1:0] selects size, funct3[2] selects zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   res = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   res = {{16{h[15] & ~f3[2]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        if (f3[1:0] == 2'b00) begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = wdata[15:0];
        end else begin
            res[15:0] = wdata[15:0];
        end
        return res;
    endfunction

    // Request decode: either flag bad requests or coerce them into a legal access.
    always_comb begin
        req_err  = 1'b0;
        req_f3   = req_funct3_i;
        req_addr = req_addr_i;
`ifdef LSU_ERR_EN
        case (req_funct3_i)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = req_addr_i[0];
            F3_W:        req_err = (req_addr_i[1:0] != 2'b00);
            default:     req_err = 1'b1;
        endcase
        if (req_store_i && req_funct3_i[2]) begin
            req_err = 1'b1;
        end
`else
        case (req_funct3_i)
            F3_B:        req_f3 = F3_B;
            F3_H:        req_f3 = F3_H;
            F3_BU:       req_f3 = req_store_i ? F3_W : F3_BU;
            F3_HU:       req_f3 = req_store_i ? F3_W : F3_HU;
            default:     req_f3 = F3_W;
        endcase
        case (req_f3[1:0])
            2'b00:   req_addr = req_addr_i;
            2'b01:   req_addr = {req_addr_i[ADDR_W-1:1], 1'b0};
            default: req_addr = {req_addr_i[ADDR_W-1:2], 2'b00};
        endcase
`endif
    end

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    store_d  = req_store_i;
                    funct3_d = req_f3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_store_i && req_f3 == F3_W) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (store_q) begin
                    wdata_d = store_merge(funct3_q, addr_q[1:0], mem_rdata_i, wdata_q);
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_extract(funct3_q, addr_q[1:0], mem_rdata_i);
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs are gated by rst so a WR cycle coinciding with reset never reaches memory.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = 32'h0;
        resp_err_o   = 1'b0;
        mem_addr_o   = '0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_wdata_o  = 32'h0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_o = 1'b1;
                end
                ST_RD: begin
                    mem_read_o = 1'b1;
                    mem_addr_o = word_addr;
                end
                ST_WR: begin
                    mem_write_o = 1'b1;
                    mem_addr_o  = word_addr;
                    mem_wdata_o = wdata_q;
                end
                ST_RESP: begin
                    resp_valid_o = 1'b1;
                    resp_rdata_o = rdata_q;
                    resp_err_o   = err_q;
                end
                default: begin
                    req_ready_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a small word memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_mis = 0;

    int          r_cyc;
    logic [31:0] r_data;
    logic        r_err;
    logic [7:0]  r_rd_mask;
    logic [7:0]  r_wr_mask;
    logic [31:0] r_rd_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_store_i  (req_store_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    assign mem_rdata_i = mem[mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
    end

    // Issues one request from IDLE with resp_ready_i high and records per-cycle memory activity.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        r_cyc = -1; r_data = 32'h0; r_err = 1'b0;
        r_rd_mask = 8'h0; r_wr_mask = 8'h0;
        r_rd_addr = 32'h0; r_wr_addr = 32'h0; r_wr_data = 32'h0;
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
        for (int c = 0; c < 16; c++) begin
            if (c < 8 && mem_read_o)  begin r_rd_mask[c] = 1'b1; r_rd_addr = mem_addr_o; end
            if (c < 8 && mem_write_o) begin r_wr_mask[c] = 1'b1; r_wr_addr = mem_addr_o; r_wr_data = mem_wdata_o; end
            if (resp_valid_o) begin
                r_cyc = c; r_data = resp_rdata_o; r_err = resp_err_o;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            req_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h0; req_wdata_i = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_mis++; $display("FAIL rst_req_ready: got %b want 0", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_mis++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); end
        n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b00) begin n_mis++; $display("FAIL rst_mem_en: got %b want 00", {mem_read_o, mem_write_o}); end
        n_cmp++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin n_mis++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr_o, mem_wdata_o); end
        n_cmp++; if (resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin n_mis++; $display("FAIL rst_resp_bus: got %h/%b want 0/0", resp_rdata_o, resp_err_o); end
        req_valid_i = 1'b0; rst = 1'b0; resp_ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_mis++; $display("FAIL idle_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_mis++; $display("FAIL idle_resp_valid: got %b want 0", resp_valid_o); end
    endtask

    task automatic test_lw();
        mem[0] = 32'hDEADBEEF;
        run_req(1'b0, 3'b010, 32'h0, 32'h0);
        n_cmp++; if (r_cyc != 2) begin n_mis++; $display("FAIL lw_latency: got %0d want 2", r_cyc); end
        n_cmp++; if (r_data !== 32'hDEADBEEF) begin n_mis++; $display("FAIL lw_data: got %h want deadbeef", r_data); end
        n_cmp++; if (r_err !== 1'b0) begin n_mis++; $display("FAIL lw_err: got %b want 0", r_err); end
        n_cmp++; if (r_rd_mask !== 8'b0000_0010) begin n_mis++; $display("FAIL lw_read_cycles: got %b want 00000010", r_rd_mask); end
        n_cmp++; if (r_wr_mask !== 8'h0) begin n_mis++; $display("FAIL lw_no_write: got %b want 0", r_wr_mask); end
        n_cmp++; if (r_rd_addr !== 32'h0) begin n_mis++; $display("FAIL lw_addr: got %h want 0", r_rd_addr); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ad [5]  = '{32'h3, 32'h3, 32'h0, 32'h2, 32'h1};
        logic [31:0] ex [5]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFFFBE};
        mem[0] = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3[i], ad[i], 32'h0);
            n_cmp++; if (r_data !== ex[i] || r_cyc != 2) begin n_mis++; $display("FAIL subword_load_%0d: got %h@%0d want %h@2", i, r_data, r_cyc, ex[i]); end
        end
    endtask

    task automatic test_sub_store();
        mem[0] = 32'hDEADBEEF;
        run_req(1'b1, 3'b000, 32'h1, 32'h12345677);
        n_cmp++; if (r_rd_mask !== 8'b0000_0010) begin n_mis++; $display("FAIL sb_read_cycles: got %b want 00000010", r_rd_mask); end
        n_cmp++; if (r_wr_mask !== 8'b0000_0100) begin n_mis++; $display("FAIL sb_write_cycles: got %b want 00000100", r_wr_mask); end
        n_cmp++; if (r_wr_addr !== 32'h0 || r_wr_data !== 32'hDEAD77EF) begin n_mis++; $display("FAIL sb_write: got %h:%h want 0:dead77ef", r_wr_addr, r_wr_data); end
        n_cmp++; if (r_cyc != 3 || r_data !== 32'h0) begin n_mis++; $display("FAIL sb_resp: got %h@%0d want 0@3", r_data, r_cyc); end
        run_req(1'b0, 3'b010, 32'h0, 32'h0);
        n_cmp++; if (r_data !== 32'hDEAD77EF) begin n_mis++; $display("FAIL sb_readback: got %h want dead77ef", r_data); end
        mem[1] = 32'h11223344;
        run_req(1'b1, 3'b001, 32'h6, 32'hAAAA5566);
        n_cmp++; if (r_wr_addr !== 32'h4 || r_wr_data !== 32'h55663344 || r_cyc != 3) begin n_mis++; $display("FAIL sh_write: got %h:%h@%0d want 4:55663344@3", r_wr_addr, r_wr_data, r_cyc); end
        run_req(1'b0, 3'b010, 32'h4, 32'h0);
        n_cmp++; if (r_data !== 32'h55663344) begin n_mis++; $display("FAIL sh_readback: got %h want 55663344", r_data); end
    endtask

    task automatic test_sw();
        mem[4] = 32'h0;
        run_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
        n_cmp++; if (r_rd_mask !== 8'h0) begin n_mis++; $display("FAIL sw_no_read: got %b want 0", r_rd_mask); end
        n_cmp++; if (r_wr_mask !== 8'b0000_0010) begin n_mis++; $display("FAIL sw_write_cycles: got %b want 00000010", r_wr_mask); end
        n_cmp++; if (r_wr_addr !== 32'h10 || r_wr_data !== 32'hCAFEF00D) begin n_mis++; $display("FAIL sw_write: got %h:%h want 10:cafef00d", r_wr_addr, r_wr_data); end
        n_cmp++; if (r_cyc != 2) begin n_mis++; $display("FAIL sw_latency: got %0d want 2", r_cyc); end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        n_cmp++; if (r_data !== 32'hCAFEF00D) begin n_mis++; $display("FAIL sw_readback: got %h want cafef00d", r_data); end
    endtask

    task automatic test_misaligned();
        mem[0] = 32'hDEADBEEF;
        run_req(1'b0, 3'b001, 32'h1, 32'h0);
`ifdef LSU_ERR_EN
        n_cmp++; if (r_cyc != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin n_mis++; $display("FAIL lh_misaligned: got %h/%b@%0d want 0/1@1", r_data, r_err, r_cyc); end
        n_cmp++; if (r_rd_mask !== 8'h0 || r_wr_mask !== 8'h0) begin n_mis++; $display("FAIL lh_misaligned_mem: got %b/%b want 0/0", r_rd_mask, r_wr_mask); end
        run_req(1'b0, 3'b011, 32'h0, 32'h0);
        n_cmp++; if (r_cyc != 1 || r_err !== 1'b1) begin n_mis++; $display("FAIL illegal_f3: got %b@%0d want 1@1", r_err, r_cyc); end
`else
        n_cmp++; if (r_cyc != 2 || r_err !== 1'b0 || r_data !== 32'hFFFFBEEF) begin n_mis++; $display("FAIL lh_misaligned: got %h/%b@%0d want ffffbeef/0@2", r_data, r_err, r_cyc); end
        n_cmp++; if (r_rd_mask !== 8'b0000_0010) begin n_mis++; $display("FAIL lh_misaligned_mem: got %b want 00000010", r_rd_mask); end
        run_req(1'b0, 3'b011, 32'h0, 32'h0);
        n_cmp++; if (r_cyc != 2 || r_data !== 32'hDEADBEEF) begin n_mis++; $display("FAIL illegal_f3: got %h@%0d want deadbeef@2", r_data, r_cyc); end
`endif
    endtask

    task automatic test_backpressure();
        mem[2] = 32'h0BADF00D;
        mem[12] = 32'h0;
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h8; req_wdata_i = 32'h0;
        @(posedge clk); #1;
        req_store_i = 1'b1; req_addr_i = 32'h30; req_wdata_i = 32'h77777777;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h0BADF00D) begin n_mis++; $display("FAIL bp_hold_%0d: got %b/%h want 1/0badf00d", i, resp_valid_o, resp_rdata_o); end
            n_cmp++; if (req_ready_o !== 1'b0 || mem_write_o !== 1'b0) begin n_mis++; $display("FAIL bp_blocked_%0d: got ready=%b wr=%b want 0/0", i, req_ready_o, mem_write_o); end
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0; resp_ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_mis++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", resp_valid_o, req_ready_o); end
        n_cmp++; if (mem[12] !== 32'h0) begin n_mis++; $display("FAIL bp_ignored_req: got %h want 0", mem[12]); end
    endtask

    task automatic test_reset_mid();
        mem[3] = 32'h01020304;
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'b000; req_addr_i = 32'hC; req_wdata_i = 32'hFF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n_cmp++; if (mem_read_o !== 1'b1) begin n_mis++; $display("FAIL rmid_read: got %b want 1", mem_read_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_write_o !== 1'b0 || mem_wdata_o !== 32'h0) begin n_mis++; $display("FAIL rmid_write_gated: got %b/%h want 0/0", mem_write_o, mem_wdata_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin n_mis++; $display("FAIL rmid_idle: got ready=%b valid=%b want 1/0", req_ready_o, resp_valid_o); end
        run_req(1'b0, 3'b010, 32'hC, 32'h0);
        n_cmp++; if (r_data !== 32'h01020304) begin n_mis++; $display("FAIL rmid_mem_unchanged: got %h want 01020304", r_data); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_lw();
        test_subword_loads();
        test_sub_store();
        test_sw();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
